// File: rtl/mac_lane_array.sv
// mac_lane_array: LANES-wide multiply-accumulate engine.
//
// Each accumulation step broadcasts one coefficient from an external ROM to
// every lane. Each lane multiplies that coefficient by its own element of
// x_vec and accumulates the product over DEPTH steps. The result is then
// offered to the consumer through a valid/ready handshake.
//
// Optional feature macro: MAC_LANE_SAT_EN
//   When defined, the accumulators saturate instead of wrapping, and the
//   o_sat_flag output is added. o_sat_flag holds one sticky clamp flag per lane.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start         begin a new accumulation (honoured only in IDLE)
//   i_clear         synchronous abort to IDLE; overrides every other input
//   i_signed_mode   1 = two's-complement operands; sampled on accepted start
//   i_in_valid      x_vec valid for the current step
//   i_x_vec         lane i element at [i*DATA_W +: DATA_W]
//   i_coef          ROM read data, one-cycle latency from o_coef_addr
//   o_coef_addr     ROM read address (index of the next step)
//   o_in_ready      high in RUN
//   o_acc_out       lane i accumulator at [i*ACC_W +: ACC_W]
//   o_out_valid     result available (DONE)
//   i_out_ready     consumer accepts result
//   o_busy          high in RUN or DONE
//   o_sat_flag      (MAC_LANE_SAT_EN only) per-lane sticky clamp flag
module mac_lane_array #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_clear,
  input  logic                    i_signed_mode,
  input  logic                    i_in_valid,
  input  logic [LANES*DATA_W-1:0] i_x_vec,
  input  logic [COEF_W-1:0]       i_coef,
  output logic [ADDR_W-1:0]       o_coef_addr,
  output logic                    o_in_ready,
  output logic [LANES*ACC_W-1:0]  o_acc_out,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_busy
`ifdef MAC_LANE_SAT_EN
  ,
  output logic [LANES-1:0]        o_sat_flag
`endif
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_k;
  logic [ACC_W-1:0]    r_acc [LANES];
  logic                r_mode;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic                w_fire;
  logic                w_last;
  logic [PROD_W-1:0]   w_x_ext  [LANES];
  logic [PROD_W-1:0]   w_c_ext;
  logic [PROD_W-1:0]   w_prod   [LANES];
  logic [ACC_W-1:0]    w_prod_a [LANES];
  logic [ACC_W-1:0]    w_acc_nx [LANES];

`ifdef MAC_LANE_SAT_EN
  logic [LANES-1:0]    r_sat;
  logic [LANES-1:0]    w_clamp;
  logic [ACC_W:0]      w_sum    [LANES];
`endif

  assign w_fire = (r_state == StRun) && i_in_valid;
  assign w_last = (r_k == ADDR_W'(DEPTH - 1));

  // Operands are widened to the full product width first, so the truncated
  // PROD_W-bit product is exact in both modes.
  always_comb begin
    w_c_ext = r_mode ? PROD_W'($signed(i_coef)) : PROD_W'(i_coef);
    for (int i = 0; i < LANES; i++) begin
      w_x_ext[i]  = r_mode ? PROD_W'($signed(i_x_vec[i*DATA_W +: DATA_W]))
                           : PROD_W'(i_x_vec[i*DATA_W +: DATA_W]);
      w_prod[i]   = w_x_ext[i] * w_c_ext;
      w_prod_a[i] = r_mode ? ACC_W'($signed(w_prod[i])) : ACC_W'(w_prod[i]);
    end
  end

`ifdef MAC_LANE_SAT_EN
  // In unsigned mode the carry out flags overflow. In signed mode, overflow
  // means both operands share a sign and the sum's sign differs from it.
  always_comb begin
    w_clamp = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum[i]    = {1'b0, r_acc[i]} + {1'b0, w_prod_a[i]};
      w_acc_nx[i] = w_sum[i][ACC_W-1:0];
      if (!r_mode) begin
        if (w_sum[i][ACC_W]) begin
          w_acc_nx[i] = '1;
          w_clamp[i]  = 1'b1;
        end
      end else if (r_acc[i][ACC_W-1] == w_prod_a[i][ACC_W-1] &&
                   w_sum[i][ACC_W-1] != r_acc[i][ACC_W-1]) begin
        w_acc_nx[i] = r_acc[i][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        w_clamp[i]  = 1'b1;
      end
    end
  end

  assign o_sat_flag = r_sat;
`else
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_acc_nx[i] = r_acc[i] + w_prod_a[i];
    end
  end
`endif

  // Address of the step that the next cycle will execute. This lets the
  // ROM's one-cycle latency line up with r_k whenever a step fires.
  always_comb begin
    o_coef_addr = '0;
    if (r_state == StRun) begin
      if (i_in_valid) begin
        o_coef_addr = w_last ? '0 : r_k + ADDR_W'(1);
      end else begin
        o_coef_addr = r_k;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
`ifdef MAC_LANE_SAT_EN
      r_sat       <= '0;
`endif
    end else if (i_clear) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
`ifdef MAC_LANE_SAT_EN
      r_sat       <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state    <= StRun;
            r_k        <= '0;
            r_mode     <= i_signed_mode;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
`ifdef MAC_LANE_SAT_EN
            r_sat      <= '0;
`endif
          end
        end
        StRun: begin
          if (w_fire) begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= w_acc_nx[i];
`ifdef MAC_LANE_SAT_EN
            r_sat <= r_sat | w_clamp;
`endif
            if (w_last) begin
              r_k         <= '0;
              r_state     <= StDone;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_k <= r_k + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          if (i_out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      o_acc_out[i*ACC_W +: ACC_W] = r_acc[i];
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;

endmodule

// File: doc/mac_lane_array.md
Name: mac_lane_array

Overview:
Parametrised multiply-accumulate engine for the matrix datapath.
- Broadcasts one coefficient per step from the coefficient ROM to LANES parallel lanes.
- Each lane multiplies the coefficient by its own input element and accumulates over DEPTH steps.
- Generalises the fixed 4-lane, 8-step unit: configurable widths and depth, a signed/unsigned mode, input stalls, and a valid/ready result handshake toward the controller/writeback.

Parameters:
- LANES, 4: number of parallel MAC lanes.
- DATA_W, 8: width of each X element.
- COEF_W, 8: coefficient width.
- ACC_W, 20: accumulator width per lane. Must be ≥ DATA_W+COEF_W.
- DEPTH, 8: accumulation steps per result. Must be ≥ 1.
- ADDR_W, 4: coefficient address width. 2^ADDR_W ≥ DEPTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a new accumulation; honoured only in IDLE
- clear  in  1  synchronous abort to IDLE; highest priority after reset
- signed_mode  in  1  1 = two's-complement operands; sampled on accepted start
- in_valid  in  1  x_vec valid for the current step
- x_vec  in  LANES*DATA_W  lane i element at bits [i*DATA_W +: DATA_W]
- coef  in  COEF_W  ROM read data, one-cycle latency from coef_addr
- coef_addr  out  ADDR_W  ROM read address
- in_ready  out  1  high in RUN
- acc_out  out  LANES*ACC_W  lane i result at bits [i*ACC_W +: ACC_W]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset: state = IDLE, step counter k = 0, accumulators = 0, mode register = 0. Outputs: out_valid=0, in_ready=0, busy=0, coef_addr=0, acc_out=0.
- State IDLE:
  - start=1 → next cycle RUN, accumulators zeroed, k=0, signed_mode latched.
  - in_valid and out_ready ignored.
- State RUN:
  - A step fires when in_valid=1.
  - Each firing: acc[i] ← acc[i] + ext(coef) × ext(x[i]) for every lane, and k increments.
  - On the step where k = DEPTH-1: k → 0, state → DONE.
  - in_valid=0: stall; k and accumulators hold.
- State DONE:
  - out_valid=1; acc_out shows the final sums, stable while out_valid=1.
  - out_ready=1 → IDLE next cycle.
  - start ignored until back in IDLE. The earliest restart is a start one cycle after handshake.
- coef_addr: combinational next-step index k_next. Values:
  - IDLE/DONE: 0, so the ROM preloads coef[0].
  - RUN stall: k.
  - RUN fire: k+1, or 0 on the last step.
  - Result: coef presented in a firing cycle always equals ROM[k].
- Arithmetic:
  - Product width DATA_W+COEF_W.
  - Mode 1: operands and product sign-extended to ACC_W.
  - Mode 0: zero-extended.
  - Accumulation is modulo 2^ACC_W (see SAT_EN).
- acc_out: driven from the accumulator registers in all states. Holds the last result in IDLE until the next start zeroes it.
- clear=1 (any state): next cycle IDLE, k=0, accumulators 0, out_valid=0. Overrides start, in_valid and out_ready in the same cycle.
- Reset asserted mid-operation: immediate return to reset values; no partial result is emitted.

Optional Feature:
- Macro MAC_LANE_SAT_EN.
- Defined:
  - Each lane's accumulator saturates instead of wrapping.
  - Mode 0: clamps at 2^ACC_W-1.
  - Mode 1: clamps at 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Adds output sat_flag[LANES-1:0]: sticky per lane, set on any clamp during the current accumulation, cleared on accepted start or clear, valid alongside out_valid.
- Undefined: modulo wrap, and no sat_flag port.

Test Plan:
- Defaults, unsigned: start; 8 firing cycles with x_vec = {4,3,2,1} (lane0=1) and ROM[k]=k+1 → out_valid after the 8th step, acc_out lanes = 36, 72, 108, 144; coef_addr sequence 1..7,0.
- Signed: signed_mode=1, x = 0xFF on all lanes, coef = 0x02 for 8 steps → every lane = 0xFFFF0 (-16). Same stimulus with signed_mode=0 → 0x00FF0 (4080).
- Stall: in_valid pattern 1,0,0,1,... over 8 firings → results identical to the unstalled run; coef_addr holds k during each stall; busy stays 1.
- Backpressure: out_ready=0 for 5 cycles in DONE with start pulsed → out_valid and acc_out stable, start ignored. out_ready=1 → IDLE next cycle; start one cycle later is accepted and zeroes the accumulators.
- Abort: clear asserted after step 3, with start high in the same cycle → IDLE, acc_out=0, no out_valid. A subsequent full run gives the correct sums. Reset asserted mid-RUN → all outputs at reset values at once.
- Overflow, ACC_W=16, unsigned x=255 and coef=255 for 8 steps → wrap result 0xF008 (520200 mod 65536). With MAC_LANE_SAT_EN → 0xFFFF and sat_flag all ones.
